// File: rtl/axis_wc_pkg.sv
// rtl/axis_wc_pkg.sv - shared constants and keep helper for the AXI-Stream width converters
package axis_wc_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int CNT_W  = 2;

    // Keep mask for a word whose last filled slot is cnt; big_endian mirrors the lane order.
    function automatic logic [LANES-1:0] keep_from_cnt(input logic [CNT_W-1:0] cnt,
                                                       input logic big_endian);
        logic [LANES-1:0] k;
        logic [LANES-1:0] r;
        case (cnt)
            2'd0:    k = 4'b0001;
            2'd1:    k = 4'b0011;
            2'd2:    k = 4'b0111;
            default: k = 4'b1111;
        endcase
        for (int i = 0; i < LANES; i++) begin
            r[LANES-1-i] = k[i];
        end
        return big_endian ? r : k;
    endfunction

endpackage

// File: rtl/axis8to32_if.sv
// rtl/axis8to32_if.sv - byte-in / word-out stream bundle for the 8-to-32 upsizer
import axis_wc_pkg::*;

interface axis8to32_if;
    logic [BYTE_W-1:0]       m_data;
    logic                    m_valid;
    logic                    m_last;
    logic                    m_ready;
    logic [LANES*BYTE_W-1:0] s_data;
    logic [LANES-1:0]        s_keep;
    logic                    s_last;
    logic                    s_valid;
    logic                    s_ready;

    modport slave (
        input  m_data, m_valid, m_last, s_ready,
        output m_ready, s_data, s_keep, s_last, s_valid
    );

    modport master (
        output m_data, m_valid, m_last, s_ready,
        input  m_ready, s_data, s_keep, s_last, s_valid
    );
endinterface

// File: rtl/axis8to32.sv
// rtl/axis8to32.sv - packs four 8-bit stream beats into one registered 32-bit word
import axis_wc_pkg::*;

module axis8to32 #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rstf,
    axis8to32_if.slave  bus
);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [3*BYTE_W-1:0]       acc_q, acc_d;
    logic [LANES*BYTE_W-1:0]   s_data_q, s_data_d;
    logic [LANES-1:0]          s_keep_q, s_keep_d;
    logic                      s_last_q, s_last_d;
    logic                      s_valid_q, s_valid_d;

    logic                      m_ready_w;
    logic                      in_fire;
    logic                      out_fire;
    logic                      complete;
    logic [LANES*BYTE_W-1:0]   acc_ext;
    logic [LANES*BYTE_W-1:0]   word;

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        s_data_d  = s_data_q;
        s_keep_d  = s_keep_q;
        s_last_d  = s_last_q;
        s_valid_d = s_valid_q;
        word      = '0;

        m_ready_w = ~s_valid_q | bus.s_ready;
        in_fire   = bus.m_valid & m_ready_w;
        out_fire  = s_valid_q & bus.s_ready;
        complete  = in_fire & ((cnt_q == CNT_W'(3)) | bus.m_last);

        // Slots past the current beat are forced to zero, so the stale accumulator never leaks out.
        acc_ext = {{BYTE_W{1'b0}}, acc_q};
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) == cnt_q) begin
                word[(BIG_ENDIAN ? LANES-1-i : i)*BYTE_W +: BYTE_W] = bus.m_data;
            end else if (CNT_W'(i) < cnt_q) begin
                word[(BIG_ENDIAN ? LANES-1-i : i)*BYTE_W +: BYTE_W] = acc_ext[i*BYTE_W +: BYTE_W];
            end
        end

        if (out_fire) begin
            s_valid_d = 1'b0;
        end

        if (complete) begin
            s_data_d  = word;
            s_keep_d  = keep_from_cnt(cnt_q, BIG_ENDIAN);
            s_last_d  = bus.m_last;
            s_valid_d = 1'b1;
            cnt_d     = '0;
        end else if (in_fire) begin
            for (int i = 0; i < 3; i++) begin
                if (CNT_W'(i) == cnt_q) begin
                    acc_d[i*BYTE_W +: BYTE_W] = bus.m_data;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            s_data_q  <= '0;
            s_keep_q  <= '0;
            s_last_q  <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            s_data_q  <= s_data_d;
            s_keep_q  <= s_keep_d;
            s_last_q  <= s_last_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign bus.m_ready = m_ready_w;
    assign bus.s_data  = s_data_q;
    assign bus.s_keep  = s_keep_q;
    assign bus.s_last  = s_last_q;
    assign bus.s_valid = s_valid_q;

endmodule

// File: tb/tb_axis8to32.sv
// tb/tb_axis8to32.sv - self-checking bench for axis8to32, little- and big-endian instances
module tb_axis8to32;

    logic        clk = 1'b0;
    logic        rstf;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        s_ready;
    logic        rand_ready;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;

    axis8to32_if bus0 ();
    axis8to32_if bus1 ();

    axis8to32 #(.BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .rstf(rstf), .bus(bus0));
    axis8to32 #(.BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .rstf(rstf), .bus(bus1));

    assign bus0.m_data  = m_data;
    assign bus0.m_valid = m_valid;
    assign bus0.m_last  = m_last;
    assign bus0.s_ready = s_ready;
    assign bus1.m_data  = m_data;
    assign bus1.m_valid = m_valid;
    assign bus1.m_last  = m_last;
    assign bus1.s_ready = s_ready;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] dle;
        logic [31:0] dbe;
        logic [3:0]  kle;
        logic [3:0]  kbe;
        logic        last;
    } word_t;

    word_t       expq[$];
    logic [7:0]  part[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d0, prev_d1;
    logic [3:0]  prev_k0;
    logic        prev_l0;

    // Scoreboard: words are rebuilt from the accepted byte stream, independent of the DUT internals.
    always @(negedge clk) begin
        if (!rstf) begin
            part.delete();
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            chk("m_ready_rule", {31'b0, bus0.m_ready}, {31'b0, !bus0.s_valid || s_ready});
            chk("valid_pair", {31'b0, bus1.s_valid}, {31'b0, bus0.s_valid});
            if (prev_stall) begin
                chk("stall_valid", {31'b0, bus0.s_valid}, 32'd1);
                chk("stall_data_le", bus0.s_data, prev_d0);
                chk("stall_data_be", bus1.s_data, prev_d1);
                chk("stall_keep", {28'b0, bus0.s_keep}, {28'b0, prev_k0});
                chk("stall_last", {31'b0, bus0.s_last}, {31'b0, prev_l0});
            end
            prev_stall = bus0.s_valid && !s_ready;
            prev_d0 = bus0.s_data;
            prev_d1 = bus1.s_data;
            prev_k0 = bus0.s_keep;
            prev_l0 = bus0.s_last;
            if (bus0.s_valid && s_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_word", bus0.s_data, 32'hxxxxxxxx);
                end else begin
                    word_t w;
                    w = expq.pop_front();
                    chk("sb_data_le", bus0.s_data, w.dle);
                    chk("sb_data_be", bus1.s_data, w.dbe);
                    chk("sb_keep_le", {28'b0, bus0.s_keep}, {28'b0, w.kle});
                    chk("sb_keep_be", {28'b0, bus1.s_keep}, {28'b0, w.kbe});
                    chk("sb_last", {30'b0, bus1.s_last, bus0.s_last}, {30'b0, w.last, w.last});
                end
            end
            if (m_valid && bus0.m_ready) begin
                part.push_back(m_data);
                if (part.size() == 4 || m_last) begin
                    word_t w;
                    w = '{dle: 32'h0, dbe: 32'h0, kle: 4'h0, kbe: 4'h0, last: m_last};
                    for (int i = 0; i < part.size(); i++) begin
                        w.dle = w.dle | (32'(part[i]) << (8 * i));
                        w.dbe = w.dbe | (32'(part[i]) << (8 * (3 - i)));
                        w.kle[i] = 1'b1;
                        w.kbe[3-i] = 1'b1;
                    end
                    expq.push_back(w);
                    part.delete();
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) s_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [7:0] d, input logic l);
        m_valid = 1'b1;
        m_data  = d;
        m_last  = l;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus0.m_ready) begin
                @(posedge clk);
                #1;
                m_valid = 1'b0;
                m_last  = 1'b0;
                return;
            end
        end
        chk("send_timeout", 32'd1, 32'd0);
        m_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        rstf = 1'b0;
        m_valid = 1'b0;
        m_data = 8'h00;
        m_last = 1'b0;
        s_ready = 1'b1;
        rand_ready = 1'b0;
        #12;
        chk("rst_data", bus0.s_data, 32'h0);
        chk("rst_keep", {28'b0, bus0.s_keep}, 32'h0);
        chk("rst_valid_last", {30'b0, bus0.s_valid, bus0.s_last}, 32'h0);
        chk("rst_m_ready", {31'b0, bus0.m_ready}, 32'd1);
        @(negedge clk);
        #2 rstf = 1'b1;
        idle_cycle();

        // Four bytes back-to-back: word appears only after the fourth, for one cycle.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("t1_not_yet", {31'b0, bus0.s_valid}, 32'd0);
        send(8'h44, 1'b0);
        chk("t1_valid", {31'b0, bus0.s_valid}, 32'd1);
        chk("t1_data_le", bus0.s_data, 32'h44332211);
        chk("t1_data_be", bus1.s_data, 32'h11223344);
        chk("t1_keep", {24'b0, bus1.s_keep, bus0.s_keep}, 32'h000000ff);
        chk("t1_last", {31'b0, bus0.s_last}, 32'd0);
        idle_cycle();
        chk("t1_one_cycle", {31'b0, bus0.s_valid}, 32'd0);

        // Short packet closed by m_last, then a fresh single-byte packet.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk("t3_data_le", bus0.s_data, 32'h0000BBAA);
        chk("t3_data_be", bus1.s_data, 32'hAABB0000);
        chk("t3_keep", {24'b0, bus1.s_keep, bus0.s_keep}, 32'h000000c3);
        chk("t3_last", {31'b0, bus0.s_last}, 32'd1);
        send(8'hCC, 1'b1);
        chk("t3b_data_le", bus0.s_data, 32'h000000CC);
        chk("t3b_data_be", bus1.s_data, 32'hCC000000);
        chk("t3b_keep", {24'b0, bus1.s_keep, bus0.s_keep}, 32'h00000081);
        idle_cycle();

        // Backpressure for three cycles right as the first word appears.
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        s_ready = 1'b0;
        m_valid = 1'b1;
        m_data = 8'h05;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall_m_ready", {31'b0, bus0.m_ready}, 32'd0);
            chk("t4_stall_data", bus0.s_data, 32'h04030201);
        end
        @(posedge clk);
        #1 s_ready = 1'b1;
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b0);
        chk("t4_second_word", bus0.s_data, 32'h08070605);
        idle_cycle();

        // Sustained one byte per cycle across a word boundary.
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 1'b0);
        chk("t4_no_bubble", 32'(cyc - t0), 32'd8);
        chk("t4_bubble_word", bus0.s_data, 32'h17161514);
        idle_cycle();

        // Reset mid-word: partial bytes dropped, outputs cleared without a clock edge.
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        #2 rstf = 1'b0;
        #1;
        chk("t5_async_data", bus0.s_data, 32'h0);
        chk("t5_async_keep", {28'b0, bus0.s_keep}, 32'h0);
        chk("t5_async_flags", {30'b0, bus0.s_valid, bus0.s_last}, 32'h0);
        @(negedge clk);
        #2 rstf = 1'b1;
        idle_cycle();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        chk("t5_after_reset", bus0.s_data, 32'h04030201);
        idle_cycle();

        // Random packets with random gaps and random downstream readiness.
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 13);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) idle_cycle();
                send(8'($urandom), b == len - 1);
            end
        end
        rand_ready = 1'b0;
        #1 s_ready = 1'b1;
        repeat (10) idle_cycle();
        chk("drain_words_left", 32'(expq.size()), 32'd0);
        chk("drain_bytes_left", 32'(part.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis8to32.md
Name: axis8to32

Overview:
- AXI-Stream style width upsizer: packs four consecutive 8-bit input beats into one 32-bit output word.
- Reverse direction of the 32-to-8 downsizer in the same width-converter library; placed where a byte-wide producer feeds a 32-bit datapath.
- Supports packet boundaries: m_last closes a partial word, and s_keep marks the valid byte lanes.
- Output is fully registered.

Parameters:
- BIG_ENDIAN, 0, 0: first byte of a word lands in s_data[7:0]; 1: first byte lands in s_data[31:24].

Ports:
- clk  input  1  clock, all state on rising edge
- rstf  input  1  asynchronous, active-low reset
- m_data  input  8  input byte
- m_valid  input  1  input byte valid
- m_last  input  1  input byte is last of packet
- m_ready  output  1  block can accept input byte
- s_data  output  32  packed output word
- s_keep  output  4  per-lane byte valid, bit i = s_data[8i+7:8i]
- s_last  output  1  output word ends packet
- s_valid  output  1  output word valid
- s_ready  input  1  downstream accepts output word

Behaviour:
- Reset is rstf, asynchronous, active-low; clock is clk.
- Reset values: s_data=0, s_keep=0, s_last=0, s_valid=0, byte counter cnt=0, 24-bit accumulator acc=0.
- Reset mid-word discards all partial bytes. The first beat after reset is byte 0 of a new word.
- m_ready = ~s_valid | s_ready, combinational from registered state and s_ready only. No path from m_valid, m_data or m_last.
- Input handshake: in_fire = m_valid & m_ready. Output handshake: out_fire = s_valid & s_ready.
- Completing beat: in_fire & (cnt==3 | m_last).
- Non-completing in_fire: store the byte in accumulator slot cnt, then cnt <= cnt+1.
- Completing in_fire, output register loads:
  - s_data = accumulator slots 0..cnt-1 plus the current byte in slot cnt; unfilled lanes are 0.
  - s_keep by cnt: 0→0001, 1→0011, 2→0111, 3→1111 (lane order mirrored when BIG_ENDIAN=1, e.g. cnt=0 → 1000).
  - s_last = m_last.
  - s_valid = 1, cnt <= 0. The accumulator need not be cleared; unfilled lanes are masked on load.
- Latency: s_valid asserts the cycle after the completing beat.
- Throughput: one byte per cycle sustained when s_ready is held high. No bubbles, including at word boundaries.
- Simultaneous out_fire and completing in_fire: s_valid stays 1 and the new word replaces the old one.
- out_fire without a completing beat: s_valid <= 0. s_data, s_keep and s_last hold their values (don't-care once invalid).
- Stall rules:
  - s_valid=1 & s_ready=0 → m_ready=0. Accumulator, cnt and all outputs hold stable (AXI-S stability rule).
  - m_valid=0 → no state change apart from output draining.
- m_last on the beat at cnt==3 → full word, s_keep=1111, s_last=1.
- m_last with cnt==0 → single-byte word, s_keep=0001.
- cnt wraps 3→0 only through the completing-beat rule. It never increments past 3.
- Empty packets are not representable and not required.

Decomposition:
- Package axis_wc_pkg:
  - localparam BYTE_W=8, LANES=4, CNT_W=2.
  - function keep_from_cnt(cnt, big_endian) returning 4-bit keep.
  - Shared with the 32-to-8 downsizer once that converter gains keep/last.
- No sub-module required. The output register plus its ready logic may optionally be factored into axis_out_reg (parameterised width) for reuse by other converters.

Test Plan:
- Reset then bytes 0x11,0x22,0x33,0x44 back-to-back with s_ready=1 → one word s_data=0x44332211, s_keep=1111, s_last=0, s_valid high for exactly one cycle, the cycle after 0x44.
- BIG_ENDIAN=1, same bytes → s_data=0x11223344, s_keep=1111.
- Bytes 0xAA,0xBB with m_last on 0xBB → s_data=0x0000BBAA, s_keep=0011, s_last=1. The next byte 0xCC starts a fresh word in lane 0.
- 8 bytes 0x01..0x08 continuous, s_ready low for 3 cycles when the first word appears:
  - m_ready=0 during the stall, s_data holds 0x04030201.
  - Then 0x08070605 with no byte lost or duplicated.
  - One byte per cycle with no bubble when s_ready=1 throughout.
- rstf pulsed low after 0x55,0x66 accepted (mid-word), then 0x01..0x04 → output 0x04030201. Partial bytes are dropped and outputs return to reset values asynchronously.
- Randomised m_valid/s_ready with random packet lengths 1..13 against a scoreboard model → exact data/keep/last match, no handshake protocol violations.
